pwm_audio_out: RTL and testbench
================================

// Module: pwm_audio_out
// PURPOSE
//  Downstream output stage of the audio player. Accepts unsigned PCM samples over a valid/ready
//  stream from the sample-memory reader, buffers them in a small FIFO and drives them out as PWM
//  on GPIO. Frame rate comes from a programmable CLOCK_50 divider, so tempo follows SW selection.
// PARAMETERS
//  SAMPLE_W    11   sample / duty width
//  PWM_PERIOD  701  PWM counts per frame (counter runs 0..PWM_PERIOD-1); one sample per frame
//  FIFO_DEPTH  8    sample buffer entries (power of 2, >=2)
//  DIV_W       28   width of clk_div
// PORTS
//  CLOCK_50     in   1                    system clock, 50 MHz
//  reset        in   1                    synchronous, active-high
//  clk_div      in   DIV_W                CLOCK_50 cycles per PWM count; 0 and 1 both = every cycle
//  enable       in   1                    1 = play; 0 = pause (frame counter and output held low)
//  flush        in   1                    1-cycle clear of FIFO and current duty (clip change/stop)
//  s_data       in   SAMPLE_W             sample in
//  s_valid      in   1                    s_data valid
//  s_ready      out  1                    FIFO can accept
//  pwm_out      out  2                    PWM, both bits identical (L/R)
//  sample_stb   out  1                    1-cycle pulse when a new duty is loaded
//  underrun     out  1                    1-cycle pulse: frame boundary with FIFO empty
//  level        out  $clog2(FIFO_DEPTH+1) FIFO occupancy
// BEHAVIOUR
//  Reset (sync): div_cnt=0, pwm_cnt=0, duty=0, FIFO empty; pwm_out=0, sample_stb=0, underrun=0,
//   level=0, s_ready=0 while reset high, 1 from first cycle after release.
//  Tick: div_cnt counts 0..max(clk_div,1)-1; tick=1 on terminal count, then div_cnt=0.
//   If clk_div is lowered so div_cnt >= new terminal, tick asserts that cycle and div_cnt wraps.
//  Frame: on tick, pwm_cnt increments; at PWM_PERIOD-1 it wraps to 0 (frame boundary).
//  Load: at frame boundary, FIFO non-empty -> pop head into duty, sample_stb=1 next cycle;
//   FIFO empty -> duty holds previous value, underrun=1 next cycle.
//  Output: pwm_out = {2{duty > pwm_cnt}}, registered (1-cycle latency from pwm_cnt).
//   duty=0 -> constant low; duty >= PWM_PERIOD -> constant high. Compare zero-extended, unsigned.
//  Handshake: push when s_valid && s_ready. s_ready = !full (registered state, no bypass):
//   when full, a pop in the same cycle does NOT enable a push that cycle.
//   Push into empty FIFO on a frame-boundary cycle: pop sees empty -> underrun; sample lands next frame.
//   Simultaneous push and pop (non-empty, non-full): level unchanged.
//  enable=0: div_cnt and pwm_cnt forced to 0, pwm_out=0, no pops, no stb/underrun; FIFO still
//   accepts; duty kept. Re-enable restarts the frame at pwm_cnt=0.
//  flush: next cycle FIFO empty, level=0, duty=0, pwm_cnt=0, div_cnt=0, pwm_out=0;
//   a push in the flush cycle is dropped (s_ready=0 during flush). flush beats enable.
//  reset beats flush and enable. Mid-frame reset: all state to reset values next cycle.
// STRUCTURE
//  audio_pkg: SAMPLE_W, PWM_PERIOD default, clip tick divisors DIV_FAST=50, DIV_MED=250,
//   DIV_SLOW=700, DIV_DEFAULT=10.
//  Sub-module sample_fifo (sync FIFO, DEPTH/WIDTH params, push/pop/full/empty/level, sync reset,
//   clear input); divider, frame counter and comparator live in pwm_audio_out.
// TESTING  (bench uses PWM_PERIOD=8, FIFO_DEPTH=8 unless stated)
//  1 reset 3 cycles mid-stream -> pwm_out=0, level=0, s_ready=0 during reset, s_ready=1 after.
//  2 clk_div=1, push 3 then 6 -> frame1 pwm_out high 3/8 cycles, frame2 6/8; sample_stb once/frame.
//  3 enable=0, push 9 back-to-back -> 8 accepted, s_ready=0 after 8th, level=8, 9th held by source.
//  4 one sample 5, enable, run 3 frames -> underrun pulses at frames 2,3; output stays 5/8 high.
//  5 push 0 then 9 -> frame all low, next frame all high; clk_div=4 -> each count lasts 4 cycles;
//    clk_div=0 identical to clk_div=1.
//  6 flush mid-frame with level=5 -> next cycle level=0, pwm_out=0, pwm_cnt=0; push during flush dropped.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio PWM output path.
// Clip divisors are CLOCK_50 cycles per PWM count for the clip-speed selections.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W   = 11;
    localparam int PWM_PERIOD_DEF   = 701;
    localparam int FIFO_DEPTH_DEF   = 8;
    localparam int DIV_W_DEF        = 28;

    localparam int DIV_FAST         = 50;
    localparam int DIV_MED          = 250;
    localparam int DIV_SLOW         = 700;
    localparam int DIV_DEFAULT      = 10;

    typedef enum logic [1:0] {
        CLIP_DEFAULT,
        CLIP_FAST,
        CLIP_MED,
        CLIP_SLOW
    } clip_speed_e;

    function automatic int clip_divisor(input clip_speed_e speed);
        case (speed)
            CLIP_FAST: return DIV_FAST;
            CLIP_MED:  return DIV_MED;
            CLIP_SLOW: return DIV_SLOW;
            default:   return DIV_DEFAULT;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwm_audio_out_fifo.sv
// Synchronous sample FIFO with occupancy count and a one-cycle clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int  DEPTH   = FIFO_DEPTH_DEF,
    parameter int  WIDTH   = AUDIO_SAMPLE_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LEVEL_W-1:0] level_o
);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               doPush;
    logic               doPop;

    assign full_o  = (level_q == LEVEL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign doPush  = push_i && !full_o && !clear_i;
    assign doPop   = pop_i && !empty_o && !clear_i;
    assign data_o  = mem_q[rdPtr_q];
    assign level_o = level_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (doPush && !doPop) begin
                level_d = level_q + LEVEL_W'(1);
            end else if (doPop && !doPush) begin
                level_d = level_q - LEVEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: buffers PCM samples and emits one sample per PWM frame.
// Frame timing comes from a programmable CLOCK_50 divider driving the PWM counter.
module pwm_audio_out
    import audio_pkg::*;
#(
    parameter int  SAMPLE_W   = AUDIO_SAMPLE_W,
    parameter int  PWM_PERIOD = PWM_PERIOD_DEF,
    parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int  DIV_W      = DIV_W_DEF,
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                CLOCK_50_i,
    input  logic                reset_i,
    input  logic [DIV_W-1:0]    clk_div_i,
    input  logic                enable_i,
    input  logic                flush_i,
    input  logic [SAMPLE_W-1:0] s_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic [1:0]          pwm_out_o,
    output logic                sample_stb_o,
    output logic                underrun_o,
    output logic [LEVEL_W-1:0]  level_o
);

    localparam int              CNT_W    = $clog2(PWM_PERIOD);
    localparam int              CMP_W    = max_int(SAMPLE_W, CNT_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PWM_PERIOD - 1);

    logic [DIV_W-1:0]    divCnt_q, divCnt_d;
    logic [DIV_W-1:0]    divTerm;
    logic [CNT_W-1:0]    pwmCnt_q, pwmCnt_d;
    logic [SAMPLE_W-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;
    logic                stb_q, stb_d;
    logic                underrun_q, underrun_d;
    logic                tick;
    logic                frameEnd;
    logic                push;
    logic                pop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [SAMPLE_W-1:0] fifoHead;

    // Divisors 0 and 1 both mean a PWM count every cycle; a lowered divisor
    // that leaves the counter past its new terminal ticks immediately.
    assign divTerm   = (clk_div_i <= DIV_W'(1)) ? '0 : (clk_div_i - DIV_W'(1));
    assign tick      = enable_i && !flush_i && (divCnt_q >= divTerm);
    assign frameEnd  = tick && (pwmCnt_q == LAST_CNT);
    assign pop       = frameEnd && !fifoEmpty;
    assign s_ready_o = !fifoFull && !flush_i && !reset_i;
    assign push      = s_valid_i && s_ready_o;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i   (CLOCK_50_i),
        .reset_i (reset_i),
        .clear_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (s_data_i),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (level_o)
    );

    always_comb begin
        divCnt_d   = divCnt_q;
        pwmCnt_d   = pwmCnt_q;
        duty_d     = duty_q;
        pwm_d      = 1'b0;
        stb_d      = pop;
        underrun_d = frameEnd && fifoEmpty;
        if (flush_i) begin
            divCnt_d = '0;
            pwmCnt_d = '0;
            duty_d   = '0;
        end else if (!enable_i) begin
            divCnt_d = '0;
            pwmCnt_d = '0;
        end else begin
            pwm_d = CMP_W'(duty_q) > CMP_W'(pwmCnt_q);
            if (tick) begin
                divCnt_d = '0;
                pwmCnt_d = frameEnd ? '0 : (pwmCnt_q + CNT_W'(1));
            end else begin
                divCnt_d = divCnt_q + DIV_W'(1);
            end
            if (pop) begin
                duty_d = fifoHead;
            end
        end
    end

    always_ff @(posedge CLOCK_50_i) begin
        if (reset_i) begin
            divCnt_q   <= '0;
            pwmCnt_q   <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            divCnt_q   <= divCnt_d;
            pwmCnt_q   <= pwmCnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            stb_q      <= stb_d;
            underrun_q <= underrun_d;
        end
    end

    assign pwm_out_o    = {2{pwm_q}};
    assign sample_stb_o = stb_q;
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out with an 8-count PWM frame and an 8-entry FIFO.
// Expected duty counts, strobes and underruns are worked out by hand per frame.
module tb_pwm_audio_out;

    localparam int SW = 11;
    localparam int PP = 8;
    localparam int FD = 8;
    localparam int DW = 28;
    localparam int LW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] clkDiv;
    logic          enable;
    logic          flush;
    logic [SW-1:0] sData;
    logic          sValid;
    logic          sReady;
    logic [1:0]    pwmOut;
    logic          sampleStb;
    logic          underrun;
    logic [LW-1:0] level;

    int total = 0;
    int bad   = 0;
    int highs, stbs, unds, splits;
    int accepted;

    always #5 clock = ~clock;

    pwm_audio_out #(
        .SAMPLE_W   (SW),
        .PWM_PERIOD (PP),
        .FIFO_DEPTH (FD),
        .DIV_W      (DW)
    ) dut (
        .CLOCK_50_i   (clock),
        .reset_i      (reset),
        .clk_div_i    (clkDiv),
        .enable_i     (enable),
        .flush_i      (flush),
        .s_data_i     (sData),
        .s_valid_i    (sValid),
        .s_ready_o    (sReady),
        .pwm_out_o    (pwmOut),
        .sample_stb_o (sampleStb),
        .underrun_o   (underrun),
        .level_o      (level)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [SW-1:0] value);
        sData  = value;
        sValid = 1'b1;
        step();
        sValid = 1'b0;
    endtask

    task automatic applyReset(input int cycles);
        reset  = 1'b1;
        enable = 1'b0;
        flush  = 1'b0;
        sValid = 1'b0;
        repeat (cycles) step();
        reset = 1'b0;
        step();
    endtask

    task automatic runWindow(input int n, output int h, output int s, output int u);
        h = 0;
        s = 0;
        u = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (pwmOut == 2'b11) h++;
            if (pwmOut[0] != pwmOut[1]) splits++;
            if (sampleStb) s++;
            if (underrun) u++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        clkDiv = DW'(1);
        enable = 1'b0;
        flush  = 1'b0;
        sData  = '0;
        sValid = 1'b0;
        splits = 0;

        // Power-on reset state
        repeat (2) step();
        checkOutput("rst_pwm", pwmOut, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_ready", sReady, 0);
        checkOutput("rst_stb", sampleStb, 0);
        checkOutput("rst_underrun", underrun, 0);
        reset = 1'b0;
        step();
        checkOutput("rel_ready", sReady, 1);

        // Reset held three cycles in the middle of playback
        applyStimulus(6);
        applyStimulus(6);
        applyStimulus(6);
        enable = 1'b1;
        runWindow(8, highs, stbs, unds);
        repeat (3) step();
        checkOutput("mid_pwm_high", pwmOut, 3);
        checkOutput("mid_level", level, 2);
        reset  = 1'b1;
        sValid = 1'b1;
        sData  = 1;
        #1;
        checkOutput("mid_rst_ready", sReady, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("mid_rst_pwm", pwmOut, 0);
            checkOutput("mid_rst_level", level, 0);
            checkOutput("mid_rst_ready", sReady, 0);
        end
        sValid = 1'b0;
        enable = 1'b0;
        reset  = 1'b0;
        step();
        checkOutput("mid_rel_ready", sReady, 1);
        checkOutput("mid_rel_level", level, 0);

        // Duty 3 then 6 at one count per cycle
        applyReset(1);
        clkDiv = DW'(1);
        applyStimulus(3);
        applyStimulus(6);
        checkOutput("d36_level", level, 2);
        enable = 1'b1;
        runWindow(8, highs, stbs, unds);
        checkOutput("d36_f0_high", highs, 0);
        checkOutput("d36_f0_stb", stbs, 1);
        runWindow(8, highs, stbs, unds);
        checkOutput("d36_f1_high", highs, 3);
        checkOutput("d36_f1_stb", stbs, 1);
        checkOutput("d36_f1_und", unds, 0);
        runWindow(8, highs, stbs, unds);
        checkOutput("d36_f2_high", highs, 6);
        checkOutput("d36_f2_stb", stbs, 0);
        checkOutput("d36_f2_und", unds, 1);
        checkOutput("pwm_bits_equal", splits, 0);

        // Fill while paused: 8 accepted, 9th held until a pop frees a slot
        applyReset(1);
        accepted = 0;
        sData    = 1;
        sValid   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (sReady) accepted++;
            step();
            sData = SW'(accepted + 1);
        end
        checkOutput("fill_accepted", accepted, 8);
        checkOutput("fill_level", level, 8);
        checkOutput("fill_ready", sReady, 0);
        enable = 1'b1;
        runWindow(8, highs, stbs, unds);
        checkOutput("fill_pop_level", level, 7);
        checkOutput("fill_pop_ready", sReady, 1);
        step();
        checkOutput("fill_refill_level", level, 8);
        checkOutput("fill_first_high", pwmOut, 3);
        sValid = 1'b0;
        runWindow(7, highs, stbs, unds);
        checkOutput("fill_d1_rest", highs, 0);
        checkOutput("fill_d1_stb", stbs, 1);
        runWindow(8, highs, stbs, unds);
        checkOutput("fill_d2_high", highs, 2);

        // Single sample followed by underruns; duty held
        applyReset(1);
        applyStimulus(5);
        enable = 1'b1;
        runWindow(8, highs, stbs, unds);
        checkOutput("und_f0_stb", stbs, 1);
        checkOutput("und_f0_und", unds, 0);
        runWindow(8, highs, stbs, unds);
        checkOutput("und_f1_high", highs, 5);
        checkOutput("und_f1_und", unds, 1);
        checkOutput("und_f1_stb", stbs, 0);
        runWindow(8, highs, stbs, unds);
        checkOutput("und_f2_high", highs, 5);
        checkOutput("und_f2_und", unds, 1);

        // Duty extremes: 0 is always low, 9 (>= period) is always high
        applyReset(1);
        applyStimulus(0);
        applyStimulus(9);
        enable = 1'b1;
        runWindow(8, highs, stbs, unds);
        runWindow(8, highs, stbs, unds);
        checkOutput("ext_zero_high", highs, 0);
        checkOutput("ext_zero_stb", stbs, 1);
        runWindow(8, highs, stbs, unds);
        checkOutput("ext_full_high", highs, 8);
        checkOutput("ext_full_und", unds, 1);

        // clk_div=4: each count lasts four cycles
        applyReset(1);
        clkDiv = DW'(4);
        applyStimulus(2);
        enable = 1'b1;
        runWindow(32, highs, stbs, unds);
        checkOutput("div4_f0_high", highs, 0);
        checkOutput("div4_f0_stb", stbs, 1);
        runWindow(32, highs, stbs, unds);
        checkOutput("div4_f1_high", highs, 8);
        checkOutput("div4_f1_und", unds, 1);

        // clk_div=0 behaves exactly like clk_div=1
        applyReset(1);
        clkDiv = '0;
        applyStimulus(3);
        enable = 1'b1;
        runWindow(8, highs, stbs, unds);
        checkOutput("div0_f0_stb", stbs, 1);
        runWindow(8, highs, stbs, unds);
        checkOutput("div0_f1_high", highs, 3);
        checkOutput("div0_f1_und", unds, 1);

        // Lowering clk_div below the running divider count ticks at once
        applyReset(1);
        clkDiv = DW'(8);
        enable = 1'b1;
        repeat (5) step();
        checkOutput("lower_div_cnt", dut.divCnt_q, 5);
        checkOutput("lower_pwm_cnt0", dut.pwmCnt_q, 0);
        clkDiv = DW'(2);
        step();
        checkOutput("lower_tick_pwm", dut.pwmCnt_q, 1);
        checkOutput("lower_tick_div", dut.divCnt_q, 0);
        repeat (2) step();
        checkOutput("lower_next_pwm", dut.pwmCnt_q, 2);

        // Flush mid-frame with five samples queued
        applyReset(1);
        clkDiv = DW'(1);
        for (int i = 0; i < 6; i++) applyStimulus(4);
        checkOutput("fl_level6", level, 6);
        enable = 1'b1;
        runWindow(8, highs, stbs, unds);
        checkOutput("fl_level5", level, 5);
        repeat (3) step();
        checkOutput("fl_pre_pwm", pwmOut, 3);
        flush  = 1'b1;
        sValid = 1'b1;
        sData  = 7;
        #1;
        checkOutput("fl_ready", sReady, 0);
        step();
        flush  = 1'b0;
        sValid = 1'b0;
        checkOutput("fl_level", level, 0);
        checkOutput("fl_pwm", pwmOut, 0);
        checkOutput("fl_pwm_cnt", dut.pwmCnt_q, 0);
        checkOutput("fl_div_cnt", dut.divCnt_q, 0);
        checkOutput("fl_duty", dut.duty_q, 0);
        runWindow(8, highs, stbs, unds);
        checkOutput("fl_after_high", highs, 0);
        checkOutput("fl_after_stb", stbs, 0);
        checkOutput("fl_after_und", unds, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
